lfsr_fib_param: RTL and testbench
=================================

Name: lfsr_fib_param

Overview:
- Parametrised Fibonacci LFSR pseudo-random generator. Width, tap mask, seed and feedback polarity are configurable.
- Over a fixed-function shift-register generator it adds:
  - step enable
  - runtime seed load
  - lock-up state detection with automatic reseed
  - period measurement with a wrap pulse
- Used as the PRBS/pattern source in test and scrambling paths.

Parameters:
- WIDTH, 11: number of register stages (2..32).
- TAPS, 11'h500: feedback tap mask. Bit i set means stage i+1 feeds the XOR. Default taps stages 11 and 9 (x^11+x^9+1).
- SEED, all ones: value loaded on reset and on lock-up recovery. Must not equal the lock-up state.
- XNOR_FB, 0: 0 selects XOR feedback (lock-up state all zeros). 1 selects XNOR feedback (lock-up state all ones).
- CNT_W, WIDTH+1: width of the step counter and the period register.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- en  input  1  advance the LFSR one step this cycle.
- load  input  1  load load_value this cycle.
- load_value  input  WIDTH  value to load.
- state  output  WIDTH  current register contents; bit 0 = stage 1 (feedback input).
- bit_out  output  1  serial output, equal to state[WIDTH-1].
- lockup  output  1  one-cycle pulse: lock-up state was detected and replaced by SEED.
- wrap  output  1  one-cycle pulse: a step returned the state to SEED.
- period  output  CNT_W  steps between the last two visits to SEED (0 until the first wrap).
- step_count  output  CNT_W  steps since the last reset, load or wrap.

Behaviour:
- All outputs are registered; there is no combinational path from inputs to outputs.
- Feedback:
  - fb = XOR of state[i] over every i with TAPS[i]=1.
  - fb is inverted when XNOR_FB=1.
- Step: next state = {state[WIDTH-2:0], fb}, i.e. shift toward the MSB and insert fb at bit 0.
- Priority per cycle is rst > load > en > hold.
- Reset:
  - state=SEED; step_count=0, period=0.
  - lockup=0, wrap=0.
  - Reset mid-sequence discards all history.
- Load:
  - state=load_value and step_count=0; period is unchanged.
  - If load_value equals the lock-up state: state=SEED instead, and lockup=1 next cycle.
  - en in the same cycle is ignored.
- Step (en=1, load=0):
  - state advances and step_count increments.
  - If the new state equals SEED:
    - wrap=1 next cycle
    - period=step_count+1
    - step_count=0
  - If the register is ever found in the lock-up state during a step: next state=SEED, lockup=1, step_count=0.
- Hold (en=0, load=0): state and counters are unchanged; lockup and wrap are 0.
- Pulses:
  - lockup and wrap are high for exactly one cycle after the triggering edge.
  - Both are 0 at any time with no triggering event.
- Counter saturation: step_count saturates at 2^CNT_W-1 and does not wrap to 0. This only matters for non-maximal taps with a cycle excluding SEED.
- With maximal-length TAPS and the default polarity, the period is 2^WIDTH-1.

Test Plan:
- Reset defaults (WIDTH=11, TAPS=0x500, SEED=0x7FF) → state=0x7FF, step_count=0, period=0, lockup=0, wrap=0.
- Step sequence: en=1 for 3 cycles → state 0x7FE, 0x7FC, 0x7F8; bit_out=1 each cycle; step_count=3.
- Full period: en=1 for 2047 cycles → wrap pulses once on the 2047th step, state=0x7FF, period=2047, step_count=0.
- Lock-up recovery: load=1 with load_value=0x000 → state=0x7FF next cycle, lockup=1 for one cycle. With XNOR_FB=1, loading 0x7FF gives the same response.
- Priority and hold:
  - load=1 and en=1 with load_value=0x123 → state=0x123, step_count=0.
  - en=0 for 5 cycles → state stays 0x123.
  - rst asserted mid-run → state=0x7FF, counters 0.
- Small width (WIDTH=4, TAPS=0xC, SEED=0xF): 15 steps → visits 15 distinct nonzero states, wrap on step 15, period=15.

Source files
------------

// File: rtl/lfsr_fib_param.sv
// Fibonacci LFSR pattern source with step enable, runtime load, lock-up
// recovery to SEED and period measurement between successive SEED visits.
module lfsr_fib_param #(
    parameter int unsigned      WIDTH   = 11,
    parameter logic [WIDTH-1:0] TAPS    = WIDTH'(11'h500),
    parameter logic [WIDTH-1:0] SEED    = '1,
    parameter bit               XNOR_FB = 1'b0,
    parameter int unsigned      CNT_W   = WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] state,
    output logic             bit_out,
    output logic             lockup,
    output logic             wrap,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] step_count
);

    // The one state the feedback can never leave: all zeros for XOR, all ones for XNOR.
    localparam logic [WIDTH-1:0] LOCK_STATE = {WIDTH{XNOR_FB}};
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [WIDTH-1:0] state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             lockup_q, lockup_d;
    logic             wrap_q, wrap_d;

    logic             fb;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] cnt_inc;

    assign fb      = (^(state_q & TAPS)) ^ XNOR_FB;
    assign shifted = {state_q[WIDTH-2:0], fb};

    // Saturate so a cycle that never revisits SEED cannot alias to a short count.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        period_d = period_q;
        lockup_d = 1'b0;
        wrap_d   = 1'b0;
        if (load) begin
            cnt_d = '0;
            if (load_value == LOCK_STATE) begin
                state_d  = SEED;
                lockup_d = 1'b1;
            end else begin
                state_d = load_value;
            end
        end else if (en) begin
            if (state_q == LOCK_STATE) begin
                state_d  = SEED;
                lockup_d = 1'b1;
                cnt_d    = '0;
            end else if (shifted == SEED) begin
                state_d  = shifted;
                wrap_d   = 1'b1;
                period_d = cnt_inc;
                cnt_d    = '0;
            end else begin
                state_d = shifted;
                cnt_d   = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SEED;
            cnt_q    <= '0;
            period_q <= '0;
            lockup_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            lockup_q <= lockup_d;
            wrap_q   <= wrap_d;
        end
    end

    assign state      = state_q;
    assign bit_out    = state_q[WIDTH-1];
    assign lockup     = lockup_q;
    assign wrap       = wrap_q;
    assign period     = period_q;
    assign step_count = cnt_q;

endmodule

// File: tb/tb_lfsr_fib_param.sv
// Bench for lfsr_fib_param: four configurations driven in parallel, checked
// every cycle against an arithmetic model plus hand-computed literal points.
`timescale 1ns/1ps
module tb_lfsr_fib_param;

    localparam int NI = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  = 1'b1;
    logic        en   = 1'b0;
    logic        load = 1'b0;
    logic [31:0] lv   = '0;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    logic [10:0] st0, st1;
    logic [3:0]  st2, st3;
    logic [11:0] per0, per1, sc0, sc1;
    logic [4:0]  per2, per3, sc2, sc3;
    logic [NI-1:0] bo, lk, wr;

    // u0 default XOR, u1 XNOR with seed 0, u2 4-bit maximal, u3 4-bit rotation (non-maximal)
    lfsr_fib_param u0 (.clk(clk), .rst(rst), .en(en), .load(load), .load_value(lv[10:0]),
        .state(st0), .bit_out(bo[0]), .lockup(lk[0]), .wrap(wr[0]), .period(per0), .step_count(sc0));
    lfsr_fib_param #(.WIDTH(11), .TAPS(11'h500), .SEED(11'h000), .XNOR_FB(1'b1)) u1 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_value(lv[10:0]),
        .state(st1), .bit_out(bo[1]), .lockup(lk[1]), .wrap(wr[1]), .period(per1), .step_count(sc1));
    lfsr_fib_param #(.WIDTH(4), .TAPS(4'hC), .SEED(4'hF)) u2 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_value(lv[3:0]),
        .state(st2), .bit_out(bo[2]), .lockup(lk[2]), .wrap(wr[2]), .period(per2), .step_count(sc2));
    lfsr_fib_param #(.WIDTH(4), .TAPS(4'h8), .SEED(4'hF)) u3 (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_value(lv[3:0]),
        .state(st3), .bit_out(bo[3]), .lockup(lk[3]), .wrap(wr[3]), .period(per3), .step_count(sc3));

    int unsigned p_w[NI]    = '{11, 11, 4, 4};
    int unsigned p_taps[NI] = '{32'h500, 32'h500, 32'hC, 32'h8};
    int unsigned p_seed[NI] = '{32'h7FF, 32'h000, 32'hF, 32'hF};
    int unsigned p_xn[NI]   = '{0, 1, 0, 0};

    int unsigned m_s[NI], m_cnt[NI], m_per[NI];
    int unsigned m_lock[NI], m_wrap[NI];

    function automatic int unsigned mask_of(int k);
        return (32'd1 << p_w[k]) - 32'd1;
    endfunction

    function automatic int unsigned lock_of(int k);
        return (p_xn[k] != 0) ? mask_of(k) : 32'd0;
    endfunction

    function automatic int unsigned next_of(int k, int unsigned s);
        int unsigned fb = p_xn[k];
        for (int i = 0; i < int'(p_w[k]); i++)
            if (((p_taps[k] >> i) & 1) != 0) fb = fb ^ ((s >> i) & 1);
        return ((s * 2) + fb) & mask_of(k);
    endfunction

    function automatic int unsigned sat_inc(int k, int unsigned c);
        int unsigned cmax = (32'd1 << (p_w[k] + 1)) - 32'd1;
        return (c >= cmax) ? cmax : c + 1;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            int unsigned v, nv;
            m_lock[k] = 0;
            m_wrap[k] = 0;
            v = lv & mask_of(k);
            if (rst) begin
                m_s[k] = p_seed[k]; m_cnt[k] = 0; m_per[k] = 0;
            end else if (load) begin
                m_cnt[k] = 0;
                if (v == lock_of(k)) begin m_s[k] = p_seed[k]; m_lock[k] = 1; end
                else m_s[k] = v;
            end else if (en) begin
                if (m_s[k] == lock_of(k)) begin
                    m_s[k] = p_seed[k]; m_lock[k] = 1; m_cnt[k] = 0;
                end else begin
                    nv = next_of(k, m_s[k]);
                    m_s[k] = nv;
                    if (nv == p_seed[k]) begin
                        m_wrap[k] = 1; m_per[k] = sat_inc(k, m_cnt[k]); m_cnt[k] = 0;
                    end else begin
                        m_cnt[k] = sat_inc(k, m_cnt[k]);
                    end
                end
            end
        end
    end

    task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s u%0d: got 0x%0h expected 0x%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic cmp(int k, logic [31:0] st, logic b, logic l, logic w, logic [31:0] p, logic [31:0] c);
        chk("state", k, st, m_s[k]);
        chk("bit_out", k, 32'(b), (m_s[k] >> (p_w[k] - 1)) & 32'd1);
        chk("lockup", k, 32'(l), m_lock[k]);
        chk("wrap", k, 32'(w), m_wrap[k]);
        chk("period", k, p, m_per[k]);
        chk("step_count", k, c, m_cnt[k]);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp(0, 32'(st0), bo[0], lk[0], wr[0], 32'(per0), 32'(sc0));
            cmp(1, 32'(st1), bo[1], lk[1], wr[1], 32'(per1), 32'(sc1));
            cmp(2, 32'(st2), bo[2], lk[2], wr[2], 32'(per2), 32'(sc2));
            cmp(3, 32'(st3), bo[3], lk[3], wr[3], 32'(per3), 32'(sc3));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        logic [10:0] exp_seq[3];
        bit seen0[int];
        bit seen2[int];
        int wraps0, first0, first2, per2_at15;
        exp_seq = '{11'h7FE, 11'h7FC, 11'h7F8};

        rst = 1'b1;
        tick();
        chk_on = 1'b1;
        chk("lit_rst_state", 0, 32'(st0), 32'h7FF);
        chk("lit_rst_count", 0, 32'(sc0), 32'h0);
        chk("lit_rst_period", 0, 32'(per0), 32'h0);
        chk("lit_rst_pulses", 0, 32'({lk[0], wr[0]}), 32'h0);
        chk("lit_rst_state", 1, 32'(st1), 32'h000);
        tick();

        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lit_step_state", 0, 32'(st0), 32'(exp_seq[i]));
            chk("lit_step_bit", 0, 32'(bo[0]), 32'h1);
        end
        chk("lit_step_count", 0, 32'(sc0), 32'h3);

        // Full period of u0, with the first 15 steps covering u2's whole period.
        rst = 1'b1; tick(); rst = 1'b0; en = 1'b1;
        wraps0 = 0; first0 = 0; first2 = 0; per2_at15 = 0;
        for (int i = 1; i <= 2047; i++) begin
            tick();
            seen0[int'(st0)] = 1'b1;
            if (wr[0]) begin wraps0++; if (first0 == 0) first0 = i; end
            if (i <= 15) begin
                seen2[int'(st2)] = 1'b1;
                if (wr[2] && first2 == 0) first2 = i;
                if (i == 15) per2_at15 = int'(per2);
            end
        end
        chk("lit_full_wraps", 0, 32'(wraps0), 32'd1);
        chk("lit_full_wrap_step", 0, 32'(first0), 32'd2047);
        chk("lit_full_distinct", 0, 32'(seen0.num()), 32'd2047);
        chk("lit_full_state", 0, 32'(st0), 32'h7FF);
        chk("lit_full_period", 0, 32'(per0), 32'd2047);
        chk("lit_full_count", 0, 32'(sc0), 32'd0);
        chk("lit_small_distinct", 2, 32'(seen2.num()), 32'd15);
        chk("lit_small_zero_seen", 2, 32'(seen2.exists(0)), 32'd0);
        chk("lit_small_wrap_step", 2, 32'(first2), 32'd15);
        chk("lit_small_period", 2, 32'(per2_at15), 32'd15);

        en = 1'b0; load = 1'b1; lv = 32'h000;
        tick();
        chk("lit_lock_state", 0, 32'(st0), 32'h7FF);
        chk("lit_lock_pulse", 0, 32'(lk[0]), 32'h1);
        load = 1'b0;
        tick();
        chk("lit_lock_clear", 0, 32'(lk[0]), 32'h0);
        load = 1'b1; lv = 32'h7FF;
        tick();
        chk("lit_xnor_lock_state", 1, 32'(st1), 32'h000);
        chk("lit_xnor_lock_pulse", 1, 32'(lk[1]), 32'h1);
        load = 1'b0;
        tick();
        chk("lit_xnor_lock_clear", 1, 32'(lk[1]), 32'h0);

        load = 1'b1; en = 1'b1; lv = 32'h123;
        tick();
        chk("lit_prio_state", 0, 32'(st0), 32'h123);
        chk("lit_prio_count", 0, 32'(sc0), 32'h0);
        load = 1'b0; en = 1'b0;
        repeat (5) begin
            tick();
            chk("lit_hold_state", 0, 32'(st0), 32'h123);
        end

        load = 1'b1; lv = 32'h001;
        tick();
        load = 1'b0; en = 1'b1;
        repeat (40) tick();
        chk("lit_sat_count", 3, 32'(sc3), 32'd31);

        rst = 1'b1;
        tick();
        chk("lit_midrst_state", 0, 32'(st0), 32'h7FF);
        chk("lit_midrst_count", 0, 32'(sc0), 32'h0);
        chk("lit_midrst_period", 0, 32'(per0), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            en   = ($urandom_range(0, 9) < 7);
            load = ($urandom_range(0, 19) == 0);
            rst  = ($urandom_range(0, 99) == 0);
            case ($urandom_range(0, 3))
                0:       lv = 32'h000;
                1:       lv = 32'h7FF;
                default: lv = $urandom;
            endcase
            tick();
        end
        rst = 1'b0; load = 1'b0; en = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
